stream_mux_rr: RTL

Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes, a selectable arbitration mode (fixed-priority or round-robin), optional packet locking on a `last` marker, and a registered output stage. It is the sequential successor to the team's plain 8:1 select mux. It sits wherever several producers share one downstream consumer, e.g. merging display/segment data sources on the DE0-CV board. The channel is chosen by internal arbitration, not by an external `sel`, and the winning index is reported alongside the data.

---
 rtl/stream_mux_rr.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with fixed-priority or round-robin
// arbitration, optional packet locking on `last`, and a registered output stage.
module stream_mux_rr #(
  parameter int N    = 8,
  parameter int W    = 3,
  parameter bit RR   = 1'b1,
  parameter bit LOCK = 1'b1,
  localparam int SW  = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  typedef enum logic {ARB = 1'b0, PKT = 1'b1} state_t;

  state_t        state_r, state_s;
  logic [SW-1:0] ptr_r, ptr_s;
  logic [SW-1:0] lk_r, lk_s;
  logic [SW-1:0] gidx_s;
  logic [SW-1:0] idx_s;
  logic [SW:0]   sum_s;
  logic          gvld_s;
  logic          glast_s;
  logic          can_load_s;
  logic          accept_s;
  logic [N-1:0]  grant_s;

  assign can_load_s = !out_valid | out_ready;

  // Arbitration: locked channel first, otherwise round-robin scan or lowest index.
  always_comb begin
    gidx_s = '0;
    gvld_s = 1'b0;
    sum_s  = '0;
    idx_s  = '0;
    if (state_r == PKT) begin
      gidx_s = lk_r;
      gvld_s = 1'b1;
    end else if (RR) begin
      for (int k = 0; k < N; k++) begin
        sum_s = {1'b0, ptr_r} + (SW+1)'(k);
        if (sum_s >= (SW+1)'(N)) begin
          sum_s = sum_s - (SW+1)'(N);
        end else begin
          sum_s = sum_s;
        end
        idx_s = sum_s[SW-1:0];
        if (!gvld_s && in_valid[idx_s]) begin
          gvld_s = 1'b1;
          gidx_s = idx_s;
        end else begin
          gvld_s = gvld_s;
        end
      end
    end else begin
      // Descending scan so the lowest valid index is the last one written.
      for (int k = N - 1; k >= 0; k--) begin
        if (in_valid[k]) begin
          gvld_s = 1'b1;
          gidx_s = SW'(k);
        end else begin
          gvld_s = gvld_s;
        end
      end
    end
  end

  // One-hot grant vector for the ready outputs.
  always_comb begin
    grant_s = '0;
    if (gvld_s) begin
      grant_s[gidx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign in_ready = (rst_n && can_load_s) ? grant_s : '0;
  assign accept_s = rst_n & can_load_s & gvld_s & in_valid[gidx_s];
  assign glast_s  = in_last[gidx_s];

  // Lock FSM next state and pointer update.
  always_comb begin
    state_s = state_r;
    lk_s    = lk_r;
    ptr_s   = ptr_r;
    case (state_r)
      ARB: begin
        if (LOCK && accept_s && !glast_s) begin
          state_s = PKT;
          lk_s    = gidx_s;
        end else begin
          state_s = ARB;
        end
      end
      PKT: begin
        if (accept_s && glast_s) begin
          state_s = ARB;
        end else begin
          state_s = PKT;
        end
      end
      default: state_s = ARB;
    endcase
    if (RR && accept_s && (glast_s || !LOCK)) begin
      ptr_s = (gidx_s == SW'(N - 1)) ? '0 : gidx_s + SW'(1);
    end else begin
      ptr_s = ptr_r;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ARB;
      lk_r    <= '0;
      ptr_r   <= '0;
    end else begin
      state_r <= state_s;
      lk_r    <= lk_s;
      ptr_r   <= ptr_s;
    end
  end

  // Output register: load on accept, empty on drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (accept_s) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(gidx_s)*W +: W];
      out_last  <= glast_s;
      out_sel   <= gidx_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
